spi_lcd_writer: RTL and testbench

- Sits directly downstream of the SPI slave and consumes its received-byte strobe and byte.
- Decodes an escape-prefixed byte stream into HD44780 command/data writes and buffers them in a small FIFO.
- Drives the LCD 8-bit parallel bus with parameterised setup, enable-pulse, hold and execution timing.
- Returns a status byte to the SPI slave's parallel input, so the host reads status on every transfer.

---
 rtl/lcd_pkg.sv | 41 ++++
 rtl/lcd_fifo.sv | 64 ++++++
 rtl/spi_lcd_writer.sv | 183 ++++++++++++++++++
 tb/tb_spi_lcd_writer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Purpose  : Shared types and constants for the SPI-driven HD44780 writer.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  // Writer FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_EXEC  = 3'd4
  } lcd_state_t;

  // Byte that marks the following byte as a command (RS=0)
  localparam logic [7:0] DEFAULT_ESC = 8'hFE;

  // Commands that need the long execution wait (clear / return home)
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;

  // STATUS byte bit positions; bits [2:0] carry the FIFO count
  localparam int STAT_BUSY = 7;
  localparam int STAT_OVF  = 6;
  localparam int STAT_ESC  = 5;

  // True when an entry is a command that needs the long execution wait
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] code);
    return !rs && ((code == CMD_CLEAR) || (code == CMD_HOME) || (code == CMD_HOME_ALT));
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : lcd_fifo
// Purpose  : Generic synchronous FIFO. DEPTH must be a power of two so the
//            pointers wrap naturally. A push while full is accepted only
//            when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_lcd_writer.sv
`default_nettype none
// ============================================================================
// Module   : spi_lcd_writer
// Purpose  : Decodes an escape-prefixed SPI byte stream into HD44780
//            command/data writes, queues them, and drives the 8-bit LCD bus
//            with setup / enable / hold / execution timing. Returns a status
//            byte for the SPI slave to shift back to the host.
// Revision : 1.0 - initial release
// ============================================================================
module spi_lcd_writer
  import lcd_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] ESC         = DEFAULT_ESC,
  parameter int         T_SETUP     = 2,
  parameter int         T_EPW       = 12,
  parameter int         T_HOLD      = 2,
  parameter int         T_EXEC      = 1850,
  parameter int         T_EXEC_LONG = 76000
) (
  input  logic       MCLK,
  input  logic       RST,
  input  logic [7:0] DIN,
  input  logic       DIN_VLD,
  output logic [7:0] STATUS,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [7:0] LCD_DB,
  output logic       BUSY,
  output logic       OVF
);

  localparam int CNT_MAX = max2(max2(T_SETUP, T_EPW), max2(T_HOLD, max2(T_EXEC, T_EXEC_LONG)));
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int FCW     = $clog2(FIFO_DEPTH + 1);

  lcd_state_t     state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           esc_pend, esc_nxt;
  logic           push;
  logic [8:0]     push_data;
  logic           pop;
  logic           e_nxt;
  logic [8:0]     fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;
  logic [FCW-1:0] fifo_count;
  logic [FCW-1:0] count_nxt;
  logic           push_acc;
  logic [7:0]     status_w;

  // Write queue between the byte decoder and the bus writer
  lcd_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (MCLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Escape decoder: a prefix byte turns the next byte into a command
  always_comb begin
    push      = 1'b0;
    push_data = {1'b1, DIN};
    esc_nxt   = esc_pend;
    if (DIN_VLD) begin
      if (esc_pend) begin
        push      = 1'b1;
        push_data = {1'b0, DIN};
        esc_nxt   = 1'b0;
      end else if (DIN == ESC) begin
        esc_nxt = 1'b1;
      end else begin
        push = 1'b1;
      end
    end
  end

  // FSM state and phase down-counter
  always_ff @(posedge MCLK) begin
    if (RST) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: each phase loads N-1 and advances when the counter hits zero
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == '0) ? cnt : cnt - 1'b1;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_nxt = ST_SETUP;
          cnt_nxt   = CW'(T_SETUP - 1);
        end
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          state_nxt = ST_PULSE;
          cnt_nxt   = CW'(T_EPW - 1);
        end
      end
      ST_PULSE: begin
        if (cnt == '0) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = CW'(T_HOLD - 1);
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          state_nxt = ST_EXEC;
          cnt_nxt   = is_long_cmd(LCD_RS, LCD_DB) ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);
        end
      end
      ST_EXEC: begin
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // FSM outputs: pop in IDLE when work is queued, E high throughout PULSE
  always_comb begin
    pop   = (state == ST_IDLE) && !fifo_empty;
    e_nxt = (state_nxt == ST_PULSE);
  end

  // Occupancy after this edge, so BUSY is a flop that matches the FIFO count
  assign push_acc  = push & (~fifo_full | pop);
  assign count_nxt = fifo_count + FCW'(push_acc) - FCW'(pop);

  // Registered bus, escape and flag outputs; bus loads only on IDLE->SETUP
  always_ff @(posedge MCLK) begin
    if (RST) begin
      LCD_RS   <= 1'b0;
      LCD_DB   <= 8'h00;
      LCD_E    <= 1'b0;
      esc_pend <= 1'b0;
      OVF      <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      if (pop) begin
        LCD_RS <= fifo_dout[8];
        LCD_DB <= fifo_dout[7:0];
      end
      LCD_E    <= e_nxt;
      esc_pend <= esc_nxt;
      OVF      <= OVF | (push & fifo_full & ~pop);
      BUSY     <= (state_nxt != ST_IDLE) || (count_nxt != '0);
    end
  end

  // Status byte assembled purely from registered state
  always_comb begin
    status_w            = 8'h00;
    status_w[STAT_BUSY] = BUSY;
    status_w[STAT_OVF]  = OVF;
    status_w[STAT_ESC]  = esc_pend;
    status_w[2:0]       = 3'(fifo_count);
  end

  assign STATUS = status_w;
  assign LCD_RW = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_spi_lcd_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_lcd_writer
// Purpose  : Directed self-checking bench for spi_lcd_writer. Execution
//            times are shortened so the whole run stays small.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_lcd_writer;

  localparam int TB_EXEC      = 100;
  localparam int TB_EXEC_LONG = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_vld = 1'b0;
  logic [7:0] status;
  logic       lcd_rs, lcd_rw, lcd_e, busy, ovf;
  logic [7:0] lcd_db;

  int vectors = 0;
  int miscompares = 0;
  int n;
  longint t2;

  logic [8:0] wr_q[$];
  longint     rise_q[$];
  longint     fall_q[$];
  longint     busy_fall_t = 0;

  spi_lcd_writer #(
    .FIFO_DEPTH  (4),
    .ESC         (8'hFE),
    .T_SETUP     (2),
    .T_EPW       (12),
    .T_HOLD      (2),
    .T_EXEC      (TB_EXEC),
    .T_EXEC_LONG (TB_EXEC_LONG)
  ) dut (
    .MCLK    (clk),
    .RST     (rst),
    .DIN     (din),
    .DIN_VLD (din_vld),
    .STATUS  (status),
    .LCD_RS  (lcd_rs),
    .LCD_RW  (lcd_rw),
    .LCD_E   (lcd_e),
    .LCD_DB  (lcd_db),
    .BUSY    (busy),
    .OVF     (ovf)
  );

  always #5 clk = ~clk;

  // Log every LCD write as seen on the bus when E rises
  always @(posedge lcd_e) begin
    wr_q.push_back({lcd_rs, lcd_db});
    rise_q.push_back($time);
  end

  always @(negedge lcd_e) fall_q.push_back($time);

  always @(negedge busy) busy_fall_t = $time;

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    din     = b;
    din_vld = 1'b1;
    step(1);
    din_vld = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic clear_log();
    wr_q.delete();
    rise_q.delete();
    fall_q.delete();
  endtask

  task automatic wait_idle(input int max_cycles, output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < max_cycles) begin
      step(1);
      cycles++;
    end
    chk("idle_reached", busy, 0);
  endtask

  initial begin
    // Reset state
    step(2);
    rst = 1'b0;
    chk("rst_status", status, 8'h00);
    chk("rst_e", lcd_e, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_db", lcd_db, 8'h00);
    chk("rst_rw", lcd_rw, 0);
    chk("rst_busy", busy, 0);
    step(1);
    chk("idle_status", status, 8'h00);

    // Single data write 0x41: bus at t+2, E high 12 cycles from t+4
    clear_log();
    send(8'h41);
    chk("data_t1_status", status, 8'h81);
    step(1);
    t2 = $time;
    chk("data_t2_rs", lcd_rs, 1);
    chk("data_t2_db", lcd_db, 8'h41);
    chk("data_t2_e", lcd_e, 0);
    chk("data_t2_status", status, 8'h80);
    wait_idle(500, n);
    chk("data_busy_len", n, 116);
    chk("data_done_status", status, 8'h00);
    chk("data_wr_count", wr_q.size(), 1);
    chk("data_wr0", wr_q[0], 9'h141);
    chk("data_rise_time", rise_q[0], t2 + 19);
    chk("data_e_width", fall_q[0] - rise_q[0], 120);

    // Commands: 0x01 takes the long wait, 0x80 the normal wait
    clear_log();
    send(8'hFE);
    chk("cmd_esc_pend", status, 8'h20);
    send(8'h01);
    chk("cmd1_status", status, 8'h81);
    send(8'hFE);
    chk("cmd2_esc_pend", status, 8'hA0);
    send(8'h80);
    chk("cmd2_status", status, 8'h81);
    wait_idle(2000, n);
    chk("cmd_wr_count", wr_q.size(), 2);
    chk("cmd_wr0", wr_q[0], 9'h001);
    chk("cmd_wr1", wr_q[1], 9'h080);
    chk("cmd_long_spacing", rise_q[1] - rise_q[0], (2 + 12 + 2 + TB_EXEC_LONG + 1) * 10);
    chk("cmd_short_exec", busy_fall_t - fall_q[1], (2 + TB_EXEC) * 10);
    chk("cmd_done_status", status, 8'h00);

    // Overflow: six bytes 16 cycles apart while the writer is busy
    clear_log();
    for (int i = 0; i < 6; i++) begin
      send(8'h30 + 8'(i));
      if (i < 5) step(15);
    end
    chk("ovf_status", status, 8'hC4);
    chk("ovf_flag", ovf, 1);
    wait_idle(2000, n);
    chk("ovf_wr_count", wr_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("ovf_wr", wr_q[i], 9'h130 + 9'(i));
    end
    chk("ovf_sticky_status", status, 8'h40);

    // Push on the IDLE pop cycle with the FIFO full
    do_reset();
    chk("pp_rst_status", status, 8'h00);
    clear_log();
    for (int i = 0; i < 5; i++) begin
      send(8'h50 + 8'(i));
    end
    chk("pp_full_status", status, 8'h84);
    step(113);
    send(8'h55);
    chk("pp_status", status, 8'h84);
    chk("pp_ovf", ovf, 0);
    chk("pp_db", lcd_db, 8'h51);
    chk("pp_rs", lcd_rs, 1);
    wait_idle(2000, n);
    chk("pp_wr_count", wr_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("pp_wr", wr_q[i], 9'h150 + 9'(i));
    end

    // Escaped escape byte becomes command 0xFE
    clear_log();
    send(8'hFE);
    send(8'hFE);
    send(8'h42);
    wait_idle(1000, n);
    chk("ee_wr_count", wr_q.size(), 2);
    chk("ee_wr0", wr_q[0], 9'h0FE);
    chk("ee_wr1", wr_q[1], 9'h142);
    chk("ee_status", status, 8'h00);

    // Reset during the enable pulse
    clear_log();
    send(8'h60);
    send(8'h61);
    step(2);
    chk("mid_e_high", lcd_e, 1);
    do_reset();
    chk("mid_e_low", lcd_e, 0);
    chk("mid_status", status, 8'h00);
    chk("mid_busy", busy, 0);
    chk("mid_rs", lcd_rs, 0);
    chk("mid_db", lcd_db, 8'h00);
    step(300);
    chk("mid_no_more_writes", wr_q.size(), 1);
    chk("mid_e_quiet", lcd_e, 0);
    chk("mid_final_status", status, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
